// File: rtl/state_var_updater.sv
// state_var_updater: sequences one exponent-term evaluation per evaluated state
// variable, captures each result on the evaluator ready handshake and writes it
// to state-variable memory at NUM_INIT_VAL+k, then pulses update_done.
// Optional build macro STATE_VAR_UPDATE_NAN_CHECK_EN: non-finite results are
// replaced by +0.0 and flagged on update_nan_flag (tied 0 when undefined).
`timescale 1ns/1ps
module state_var_updater #(
    parameter int unsigned NUM_INIT_VAL   = 6,
    parameter int unsigned NUM_EVAL_VAL   = 3,
    parameter int unsigned EXP_LEN        = 8,
    parameter int unsigned MANTISSA_LEN   = 23,
    parameter int unsigned DATA_WIDTH     = 1 + EXP_LEN + MANTISSA_LEN,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    localparam int unsigned ADDR_W = $clog2(NUM_INIT_VAL + NUM_EVAL_VAL),
    localparam int unsigned IDX_W  = (NUM_EVAL_VAL > 1) ? $clog2(NUM_EVAL_VAL) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_update,
    input  logic                  eval_data_ready,
    input  logic [DATA_WIDTH-1:0] eval_result,
    output logic                  eval_start,
    output logic [IDX_W-1:0]      eval_index,
    output logic [ADDR_W-1:0]     mem_state_var_write_addr,
    output logic [DATA_WIDTH-1:0] mem_state_var_write_data_in,
    output logic                  mem_state_var_write_we,
    output logic                  update_busy,
    output logic                  update_done,
    output logic                  update_timeout,
    output logic                  update_nan_flag
);

    // Watchdog counts WAIT cycles; abort fires on the cycle that would make it
    // reach TIMEOUT_CYCLES-1, landing DONE TIMEOUT_CYCLES cycles after eval_start.
    localparam int unsigned        WD_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT_CYCLES - 2);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_EVAL_VAL - 1);
    localparam logic [ADDR_W-1:0]  ADDR_BASE = ADDR_W'(NUM_INIT_VAL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          state;
    logic [WD_W-1:0] watchdog;
    logic            capture_c;

    // Ready is blanked in the first WAIT cycle (watchdog still 0) to reject stale handshakes.
    assign capture_c = eval_data_ready && (watchdog != '0);

`ifndef STATE_VAR_UPDATE_NAN_CHECK_EN
    assign update_nan_flag = 1'b0;
`endif

    // Pass sequencer with registered outputs; pulse outputs default low each cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                       <= S_IDLE;
            watchdog                    <= '0;
            eval_start                  <= 1'b0;
            eval_index                  <= '0;
            mem_state_var_write_addr    <= '0;
            mem_state_var_write_data_in <= '0;
            mem_state_var_write_we      <= 1'b0;
            update_busy                 <= 1'b0;
            update_done                 <= 1'b0;
            update_timeout              <= 1'b0;
`ifdef STATE_VAR_UPDATE_NAN_CHECK_EN
            update_nan_flag             <= 1'b0;
`endif
        end else begin
            eval_start             <= 1'b0;
            mem_state_var_write_we <= 1'b0;
            update_done            <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_update) begin
                        eval_index     <= '0;
                        update_busy    <= 1'b1;
                        update_timeout <= 1'b0;
`ifdef STATE_VAR_UPDATE_NAN_CHECK_EN
                        update_nan_flag <= 1'b0;
`endif
                        eval_start     <= 1'b1;
                        state          <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    watchdog <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (capture_c) begin
                        mem_state_var_write_we   <= 1'b1;
                        mem_state_var_write_addr <= ADDR_BASE + ADDR_W'(eval_index);
`ifdef STATE_VAR_UPDATE_NAN_CHECK_EN
                        if (&eval_result[DATA_WIDTH-2:MANTISSA_LEN]) begin
                            mem_state_var_write_data_in <= '0;
                            update_nan_flag             <= 1'b1;
                        end else begin
                            mem_state_var_write_data_in <= eval_result;
                        end
`else
                        mem_state_var_write_data_in <= eval_result;
`endif
                        state <= S_WRITE;
                    end else if (watchdog == WD_LAST) begin
                        update_timeout <= 1'b1;
                        update_done    <= 1'b1;
                        update_busy    <= 1'b0;
                        state          <= S_DONE;
                    end else begin
                        watchdog <= watchdog + WD_W'(1);
                    end
                end
                S_WRITE: begin
                    if (eval_index == IDX_LAST) begin
                        update_done <= 1'b1;
                        update_busy <= 1'b0;
                        state       <= S_DONE;
                    end else begin
                        eval_index <= eval_index + IDX_W'(1);
                        eval_start <= 1'b1;
                        state      <= S_LAUNCH;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_state_var_updater.sv
// Testbench for state_var_updater: table of directed passes, reset and
// mid-pass-start sequences, then randomized passes against a timing model.
`timescale 1ns/1ps
module tb_state_var_updater;

    localparam int T_CYC = 16;
`ifdef STATE_VAR_UPDATE_NAN_CHECK_EN
    localparam bit NAN_EN = 1'b1;
`else
    localparam bit NAN_EN = 1'b0;
`endif
    localparam logic [31:0] GARB = 32'hDEAD_0000;

    typedef struct packed {
        logic [2:0][7:0]  lat;
        logic [2:0][31:0] val;
        logic             stale;
        logic             noresp;
        logic             mid_start;
    } pass_cfg_t;

    typedef struct packed {
        pass_cfg_t   cfg;
        logic [7:0]  exp_done;
        logic        exp_to;
    } vec_t;

    typedef struct packed {
        logic [15:0] cyc;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [1:0]  idx;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start_update = 1'b0;
    logic        eval_data_ready = 1'b0;
    logic [31:0] eval_result = '0;
    logic        eval_start;
    logic [1:0]  eval_index;
    logic [3:0]  mem_state_var_write_addr;
    logic [31:0] mem_state_var_write_data_in;
    logic        mem_state_var_write_we;
    logic        update_busy;
    logic        update_done;
    logic        update_timeout;
    logic        update_nan_flag;

    int n_cmp = 0;
    int n_bad = 0;

    pass_cfg_t ev_cfg = '0;

    wr_t  m_wq[$];
    int   m_done;
    logic m_to;
    logic m_nan;
    int   m_launch;

    state_var_updater #(.TIMEOUT_CYCLES(T_CYC)) dut (
        .clock                       (clock),
        .reset                       (reset),
        .start_update                (start_update),
        .eval_data_ready             (eval_data_ready),
        .eval_result                 (eval_result),
        .eval_start                  (eval_start),
        .eval_index                  (eval_index),
        .mem_state_var_write_addr    (mem_state_var_write_addr),
        .mem_state_var_write_data_in (mem_state_var_write_data_in),
        .mem_state_var_write_we      (mem_state_var_write_we),
        .update_busy                 (update_busy),
        .update_done                 (update_done),
        .update_timeout              (update_timeout),
        .update_nan_flag             (update_nan_flag)
    );

    always #5 clock = ~clock;

    // Evaluator model: answers each eval_start after lat cycles; in stale mode
    // ready idles high with junk data, including LAUNCH and the first WAIT cycle.
    always begin : evaluator
        int k;
        int lat;
        @(negedge clock);
        if (eval_start && !ev_cfg.noresp) begin
            k = int'(eval_index);
            if (k > 2) k = 2;
            lat = int'(ev_cfg.lat[k]);
            for (int c = 1; c <= lat; c++) begin
                @(posedge clock); #1;
                if (c == lat) begin
                    eval_data_ready = 1'b1;
                    eval_result     = ev_cfg.val[k];
                end else if (c == 1 && ev_cfg.stale) begin
                    eval_data_ready = 1'b1;
                    eval_result     = GARB | 32'(k);
                end else begin
                    eval_data_ready = 1'b0;
                    eval_result     = GARB | 32'(k);
                end
            end
            @(posedge clock); #1;
            eval_data_ready = ev_cfg.stale;
            eval_result     = GARB;
        end else if (!eval_start) begin
            eval_data_ready = ev_cfg.stale;
            eval_result     = GARB;
        end
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic pass_cfg_t mk(input int l0, input int l1, input int l2,
                                     input logic [31:0] v0, input logic [31:0] v1,
                                     input logic [31:0] v2, input logic stale,
                                     input logic noresp, input logic mid);
        pass_cfg_t c;
        c.lat[0] = 8'(l0); c.lat[1] = 8'(l1); c.lat[2] = 8'(l2);
        c.val[0] = v0; c.val[1] = v1; c.val[2] = v2;
        c.stale = stale; c.noresp = noresp; c.mid_start = mid;
        return c;
    endfunction

    // Reference timing: launch at cycle s, result written at s+lat+1, next launch
    // one cycle later; no response means DONE at first launch + T_CYC.
    task automatic model_pass(input pass_cfg_t cfg);
        int          s;
        logic [31:0] v;
        wr_t         w;
        m_wq.delete();
        m_nan = 1'b0; m_to = 1'b0; m_launch = 0; s = 1;
        for (int k = 0; k < 3; k++) begin
            m_launch++;
            if (cfg.noresp) begin
                m_to = 1'b1;
                s = s + T_CYC;
                break;
            end
            v = cfg.val[k];
            if (NAN_EN && v[30:23] == 8'hFF) begin
                v = '0;
                m_nan = 1'b1;
            end
            w.cyc  = 16'(s + int'(cfg.lat[k]) + 1);
            w.addr = 4'(6 + k);
            w.data = v;
            w.idx  = 2'(k);
            m_wq.push_back(w);
            s = int'(w.cyc) + 1;
        end
        m_done = s;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".eval_start"}, 32'(eval_start), 0);
        chk({tag, ".eval_index"}, 32'(eval_index), 0);
        chk({tag, ".addr"},       32'(mem_state_var_write_addr), 0);
        chk({tag, ".data"},       mem_state_var_write_data_in, 0);
        chk({tag, ".we"},         32'(mem_state_var_write_we), 0);
        chk({tag, ".busy"},       32'(update_busy), 0);
        chk({tag, ".done"},       32'(update_done), 0);
        chk({tag, ".timeout"},    32'(update_timeout), 0);
        chk({tag, ".nan"},        32'(update_nan_flag), 0);
    endtask

    task automatic run_pass(input pass_cfg_t cfg, input int exp_done, input logic exp_to,
                            input string tag);
        wr_t  got[$];
        wr_t  w;
        int   launches = 0;
        int   c = 0;
        bit   seen = 1'b0;
        int   done_c = 0;
        logic d_busy = 1'b0;
        logic d_to = 1'b0;
        logic d_nan = 1'b0;
        int   n;
        model_pass(cfg);
        ev_cfg = cfg;
        repeat (3) @(posedge clock);
        #1 start_update = 1'b1;
        @(posedge clock);
        #1 start_update = 1'b0;
        while (!seen && c < 200) begin
            @(negedge clock);
            c++;
            if (c == 1) begin
                chk({tag, ".c1_eval_start"}, 32'(eval_start), 1);
                chk({tag, ".c1_busy"},       32'(update_busy), 1);
                chk({tag, ".c1_index"},      32'(eval_index), 0);
                chk({tag, ".c1_timeout"},    32'(update_timeout), 0);
                chk({tag, ".c1_nan"},        32'(update_nan_flag), 0);
            end
            if (cfg.mid_start && c == 6) start_update = 1'b1;
            if (c == 7) start_update = 1'b0;
            if (eval_start) launches++;
            if (mem_state_var_write_we) begin
                w.cyc = 16'(c); w.addr = mem_state_var_write_addr;
                w.data = mem_state_var_write_data_in; w.idx = eval_index;
                got.push_back(w);
            end
            if (update_done) begin
                seen = 1'b1; done_c = c;
                d_busy = update_busy; d_to = update_timeout; d_nan = update_nan_flag;
            end
        end
        start_update = 1'b0;
        chk({tag, ".done_seen"}, 32'(seen), 1);
        repeat (6) begin
            @(negedge clock);
            if (eval_start) launches++;
            if (mem_state_var_write_we) begin
                w.cyc = 16'(c); w.addr = mem_state_var_write_addr;
                w.data = mem_state_var_write_data_in; w.idx = eval_index;
                got.push_back(w);
            end
        end
        chk({tag, ".done_cycle"},  32'(done_c), 32'(exp_done));
        chk({tag, ".busy_at_done"}, 32'(d_busy), 0);
        chk({tag, ".timeout"},     32'(d_to), 32'(exp_to));
        chk({tag, ".nan_flag"},    32'(d_nan), 32'(m_nan));
        chk({tag, ".launches"},    32'(launches), 32'(m_launch));
        chk({tag, ".n_writes"},    32'(got.size()), 32'(m_wq.size()));
        n = (got.size() < m_wq.size()) ? got.size() : m_wq.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.w%0d_cycle", tag, i), 32'(got[i].cyc),  32'(m_wq[i].cyc));
            chk($sformatf("%s.w%0d_addr", tag, i),  32'(got[i].addr), 32'(m_wq[i].addr));
            chk($sformatf("%s.w%0d_data", tag, i),  got[i].data,      m_wq[i].data);
            chk($sformatf("%s.w%0d_index", tag, i), 32'(got[i].idx),  32'(m_wq[i].idx));
        end
        chk({tag, ".busy_after"}, 32'(update_busy), 0);
    endtask

    initial begin
        vec_t      tbl[7];
        pass_cfg_t cfg;
        int        c;
        bit        found;
        int        wr_during;

        tbl[0] = '{cfg: mk(5, 5, 5, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 0), exp_done: 8'd22, exp_to: 1'b0};
        tbl[1] = '{cfg: mk(4, 4, 4, 32'h4100_0000, 32'h4110_0000, 32'h4120_0000, 1, 0, 0), exp_done: 8'd19, exp_to: 1'b0};
        tbl[2] = '{cfg: mk(2, 3, 7, 32'h1234_5678, 32'h89AB_CDEF, 32'hC049_0FDB, 0, 0, 0), exp_done: 8'd19, exp_to: 1'b0};
        tbl[3] = '{cfg: mk(5, 5, 5, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 0, 1, 0), exp_done: 8'd17, exp_to: 1'b1};
        tbl[4] = '{cfg: mk(3, 3, 3, 32'h7FC0_0000, 32'h7F80_0000, 32'h3F80_0000, 0, 0, 0), exp_done: 8'd16, exp_to: 1'b0};
        tbl[5] = '{cfg: mk(5, 5, 5, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 1), exp_done: 8'd22, exp_to: 1'b0};
        tbl[6] = '{cfg: mk(2, 2, 2, 32'h4200_0000, 32'h4210_0000, 32'h4220_0000, 1, 0, 0), exp_done: 8'd13, exp_to: 1'b0};

        repeat (3) @(negedge clock);
        chk_zero("in_reset");
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk_zero("post_release");

        for (int i = 0; i < 7; i++)
            run_pass(tbl[i].cfg, int'(tbl[i].exp_done), tbl[i].exp_to, $sformatf("tbl%0d", i));

        // Reset during the second WAIT cycle of k=1: nothing may reach address 7.
        ev_cfg = tbl[0].cfg;
        repeat (3) @(posedge clock);
        #1 start_update = 1'b1;
        @(posedge clock);
        #1 start_update = 1'b0;
        c = 0; found = 1'b0; wr_during = 0;
        while (!found && c < 60) begin
            @(negedge clock);
            c++;
            if (mem_state_var_write_we && mem_state_var_write_addr == 4'd7) wr_during++;
            if (eval_index == 2'd1 && !eval_start && update_busy) found = 1'b1;
        end
        chk("rst_mid.reached_wait_k1", 32'(found), 1);
        @(posedge clock);
        #1 reset = 1'b0;
        #1 chk_zero("rst_mid.async");
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (12) begin
            @(negedge clock);
            if (mem_state_var_write_we) wr_during++;
        end
        chk("rst_mid.writes_after", 32'(wr_during), 0);
        chk("rst_mid.busy_after", 32'(update_busy), 0);
        run_pass(tbl[0].cfg, 22, 1'b0, "after_rst");

        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 3; k++) begin
                cfg.lat[k] = 8'($urandom_range(2, 9));
                cfg.val[k] = $urandom;
                if ($urandom_range(0, 3) == 0) cfg.val[k][30:23] = 8'hFF;
            end
            cfg.noresp    = ($urandom_range(0, 7) == 0);
            cfg.stale     = !cfg.noresp && ($urandom_range(0, 1) == 1);
            cfg.mid_start = ($urandom_range(0, 1) == 1);
            model_pass(cfg);
            run_pass(cfg, m_done, m_to, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
